fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch sequencer that sits downstream of the control decoder. It consumes the decoder's jump and done signals and supplies the address to the instruction ROM. Each cycle it advances the program counter sequentially or to a branch target. It also runs the Start/Done program handshake with the test harness and counts executed cycles.

## Interface
Parameters:
- PC_W, 10, program counter width; instruction ROM holds 2^PC_W 9-bit words
- CNT_W, 16, width of the executed-cycle counter

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- Start  input  1  program request from harness, level-sensitive
- StartAddr  input  PC_W  first instruction address, sampled on launch
- JumpEqual  input  1  decoder: current instruction is je
- JumpNotEqual  input  1  decoder: current instruction is jne
- Zero  input  1  ALU equal/zero flag for the current instruction
- Target  input  PC_W  branch target from the jump LUT for the current instruction
- Ack  input  1  decoder: current instruction is the halt word 9'h1FF
- ProgCtr  output  PC_W  instruction ROM address, registered
- InstValid  output  1  ProgCtr addresses an instruction being executed this cycle
- Done  output  1  program finished; held until Start drops
- CycleCnt  output  CNT_W  cycles spent in RUN for the current or last program

## Operation
- States: IDLE, RUN, HALT. Reset forces IDLE with ProgCtr=0, InstValid=0, Done=0, CycleCnt=0.
- IDLE:
  - InstValid=0, Done=0.
  - Start=1 → RUN next edge; ProgCtr←StartAddr; CycleCnt←0.
  - Start=0 → stay in IDLE; ProgCtr and CycleCnt hold.
- RUN:
  - InstValid=1. Decoder inputs describe the instruction at the current ProgCtr.
  - Next-PC priority, evaluated every edge:
    - Ack=1 → HALT; ProgCtr holds.
    - Taken = (JumpEqual & Zero) | (JumpNotEqual & ~Zero) → ProgCtr←Target.
    - Otherwise ProgCtr←ProgCtr+1, modulo 2^PC_W: 2^PC_W−1 wraps to 0, no flag.
  - JumpEqual and JumpNotEqual both high is illegal from the decoder. Per the formula, the branch is always taken.
  - Ack together with either jump: Ack wins; no branch.
  - CycleCnt increments once per RUN cycle, including the halt cycle, and saturates at 2^CNT_W−1.
  - Start is ignored in RUN; dropping it does not abort the program.
- HALT:
  - InstValid=0, Done=1; ProgCtr and CycleCnt hold.
  - Start=1 → stay in HALT.
  - Start=0 → IDLE next edge; Done drops the same edge. CycleCnt holds until the next launch.
- Reset asserted in any state returns immediately, asynchronously, to IDLE with the reset values above. The in-flight program is abandoned.

## Timing
- Instruction ROM and decoder are combinational. The instruction at ProgCtr and its decoded signals are valid in the same cycle; fetch_unit samples them at the closing edge.
- Launch latency: Start high at edge N (in IDLE) → ProgCtr=StartAddr and InstValid=1 from edge N onward.
- Sequential and taken-branch instructions each take 1 cycle; no branch penalty, no bubbles.
- Halt: Ack sampled at edge M → Done=1 after edge M.
- Done clears 1 edge after Start is sampled low. The minimum IDLE dwell before relaunch is 1 cycle.
- Outputs are registered or decoded directly from state, with no combinational path from inputs to outputs.

## Test plan
- Reset/launch: assert Reset mid-RUN → ProgCtr=0, InstValid=0, Done=0, CycleCnt=0 without waiting for a clock edge. Release Reset, then Start=1 with StartAddr=0x010 → next edge ProgCtr=0x010, InstValid=1.
- Sequential run: no jumps, Ack on the 5th instruction → ProgCtr sequence 0x010..0x014, Done=1 after the 5th edge, CycleCnt=5. ProgCtr stays 0x014.
- Branches: JumpEqual=1, Zero=1, Target=0x200 → ProgCtr=0x200. JumpEqual=1, Zero=0 → ProgCtr+1. JumpNotEqual=1, Zero=0, Target=0x033 → ProgCtr=0x033. Ack=1 with JumpEqual=1, Zero=1 → HALT, ProgCtr unchanged.
- Wrap and saturation:
  - StartAddr=0x3FF with no jump → next ProgCtr=0x000.
  - With CNT_W=4, run 20 cycles → CycleCnt holds 15.
- Handshake: Start held high after Done → Done stays 1 and the unit stays in HALT. Start low → Done=0 next edge. Start high again → relaunch with CycleCnt=0. Start dropped mid-RUN → the program still completes to Done.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program-counter and fetch sequencer.
// Launches a program on Start, steps the PC sequentially or to a branch
// target each cycle, halts on the decoder's halt acknowledge, and runs the
// Start/Done handshake. It also counts the cycles spent running, saturating.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             JumpEqual,
  input  logic             JumpNotEqual,
  input  logic             Zero,
  input  logic [PC_W-1:0]  Target,
  input  logic             Ack,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             InstValid,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             taken;
  logic             cnt_sat;

  // Branch resolution for the instruction currently at ProgCtr. If the
  // decoder ever raises both jumps, one of the two terms is true and the
  // branch is taken.
  assign taken   = (JumpEqual & Zero) | (JumpNotEqual & ~Zero);
  assign cnt_sat = &CycleCnt;

  // Status outputs are pure decodes of the state register, so no input
  // reaches an output combinationally.
  assign InstValid = (state == RUN);
  assign Done      = (state == HALT);

  // Next-state, next-PC and next-count selection.
  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no path
    // leaves it unassigned and no latch is inferred.
    state_nxt = state;
    pc_nxt    = ProgCtr;
    cnt_nxt   = CycleCnt;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = StartAddr;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        // The halt cycle still counts as a run cycle.
        if (!cnt_sat) cnt_nxt = CycleCnt + CNT_W'(1);
        // Ack outranks any jump; PC stays on the halt word.
        if (Ack) begin
          state_nxt = HALT;
        end else if (taken) begin
          pc_nxt = Target;
        end else begin
          // Natural PC_W-bit overflow gives the wrap to zero.
          pc_nxt = ProgCtr + PC_W'(1);
        end
      end
      HALT: begin
        // Done is held until the harness withdraws Start.
        if (!Start) state_nxt = IDLE;
      end
      default: begin
        // Unused encoding: recover to a clean idle.
        state_nxt = IDLE;
      end
    endcase
  end

  // State, PC and counter registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!Reset) begin
      state    <= IDLE;
      ProgCtr  <= '0;
      CycleCnt <= '0;
    end else begin
      state    <= state_nxt;
      ProgCtr  <= pc_nxt;
      CycleCnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural model of the program
// handshake predicts every output after each clock edge; a second instance
// with a 4-bit counter shares all inputs and checks counter saturation.
module tb_fetch_unit;

  localparam int PC_W   = 10;
  localparam int CNT_W  = 16;
  localparam int PC_MOD = 1 << PC_W;

  logic            Clk;
  logic            Reset;
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic            JumpEqual;
  logic            JumpNotEqual;
  logic            Zero;
  logic [PC_W-1:0] Target;
  logic            Ack;

  logic [PC_W-1:0]  ProgCtr;
  logic             InstValid;
  logic             Done;
  logic [CNT_W-1:0] CycleCnt;

  logic [PC_W-1:0] s_pc;
  logic            s_iv;
  logic            s_done;
  logic [3:0]      s_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: is a program running, is it finished, where is it,
  // and how many run cycles has it used (unbounded; clipped when compared).
  bit m_running;
  bit m_done;
  int m_pc;
  int m_cnt;

  fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual), .Zero(Zero),
    .Target(Target), .Ack(Ack),
    .ProgCtr(ProgCtr), .InstValid(InstValid), .Done(Done), .CycleCnt(CycleCnt)
  );

  fetch_unit #(.PC_W(PC_W), .CNT_W(4)) u_sat (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual), .Zero(Zero),
    .Target(Target), .Ack(Ack),
    .ProgCtr(s_pc), .InstValid(s_iv), .Done(s_done), .CycleCnt(s_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Compare every output of both instances against the model.
  task automatic chk_all(input string tag);
    chk({tag, ".pc"},    32'(ProgCtr),   32'(m_pc));
    chk({tag, ".valid"}, 32'(InstValid), 32'(m_running));
    chk({tag, ".done"},  32'(Done),      32'(m_done));
    chk({tag, ".cnt"},   32'(CycleCnt),  32'(clip(m_cnt, (1 << CNT_W) - 1)));
    chk({tag, ".cnt4"},  32'(s_cnt),     32'(clip(m_cnt, 15)));
    chk({tag, ".pc4"},   32'(s_pc),      32'(m_pc));
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_done    = 1'b0;
    m_pc      = 0;
    m_cnt     = 0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check #1 later.
  task automatic cycle(input string tag, input bit st, input int sa,
                       input bit je, input bit jne, input bit z,
                       input int tgt, input bit ack);
    Start        = st;
    StartAddr    = PC_W'(sa);
    JumpEqual    = je;
    JumpNotEqual = jne;
    Zero         = z;
    Target       = PC_W'(tgt);
    Ack          = ack;
    @(posedge Clk);
    if (m_running) begin
      m_cnt++;
      if (ack) begin
        m_running = 1'b0;
        m_done    = 1'b1;
      end else if ((je && z) || (jne && !z)) begin
        m_pc = tgt % PC_MOD;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end else if (m_done) begin
      if (!st) m_done = 1'b0;
    end else if (st) begin
      m_running = 1'b1;
      m_pc      = sa % PC_MOD;
      m_cnt     = 0;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic run(input string tag, input bit st);
    cycle(tag, st, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0; StartAddr = '0; JumpEqual = 1'b0; JumpNotEqual = 1'b0;
    Zero = 1'b0; Target = '0; Ack = 1'b0;
    model_reset();
    #3;
    chk_all("reset0");
    #4 Reset = 1'b1;  // released between edges

    // Launch, run a little, then reset mid-RUN without a clock edge.
    cycle("launch0", 1'b1, 'h010, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("launch0.addr", 32'(ProgCtr), 32'h010);
    chk("launch0.iv",   32'(InstValid), 32'd1);
    run("pre_rst1", 1'b1);
    run("pre_rst2", 1'b1);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    #2 Reset = 1'b1;

    // Sequential run, halt on the 5th instruction.
    cycle("seq_launch", 1'b1, 'h010, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) run("seq_step", 1'b1);
    cycle("seq_halt", 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("seq_halt.pc",   32'(ProgCtr),  32'h014);
    chk("seq_halt.cnt",  32'(CycleCnt), 32'd5);
    chk("seq_halt.done", 32'(Done),     32'd1);
    // Start held high keeps HALT; dropping it returns to IDLE.
    run("hold_halt1", 1'b1);
    run("hold_halt2", 1'b1);
    run("drop_start", 1'b0);
    chk("drop_start.done", 32'(Done), 32'd0);
    run("idle_stay", 1'b0);

    // Branches.
    cycle("br_launch", 1'b1, 'h100, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("br_launch.cnt", 32'(CycleCnt), 32'd0);
    cycle("je_taken",    1'b1, 0, 1'b1, 1'b0, 1'b1, 'h200, 1'b0);
    chk("je_taken.pc", 32'(ProgCtr), 32'h200);
    cycle("je_nottaken", 1'b1, 0, 1'b1, 1'b0, 1'b0, 'h3AA, 1'b0);
    chk("je_nottaken.pc", 32'(ProgCtr), 32'h201);
    cycle("jne_taken",   1'b1, 0, 1'b0, 1'b1, 1'b0, 'h033, 1'b0);
    chk("jne_taken.pc", 32'(ProgCtr), 32'h033);
    cycle("jne_nottaken", 1'b1, 0, 1'b0, 1'b1, 1'b1, 'h2BB, 1'b0);
    cycle("both_jumps",  1'b1, 0, 1'b1, 1'b1, 1'b0, 'h055, 1'b0);
    chk("both_jumps.pc", 32'(ProgCtr), 32'h055);
    cycle("ack_vs_je",   1'b1, 0, 1'b1, 1'b0, 1'b1, 'h111, 1'b1);
    chk("ack_vs_je.pc", 32'(ProgCtr), 32'h055);
    run("br_drop", 1'b0);

    // Wrap at the top of the ROM, Start dropped mid-RUN, 20+ cycle run.
    cycle("wrap_launch", 1'b1, 'h3FF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run("wrap_step", 1'b0);
    chk("wrap_step.pc", 32'(ProgCtr), 32'h000);
    for (int i = 0; i < 20; i++) run("long_run", 1'b0);
    cycle("long_halt", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("long_halt.cnt4", 32'(s_cnt), 32'd15);
    chk("long_halt.cnt",  32'(CycleCnt), 32'd22);
    run("long_idle", 1'b0);
    cycle("relaunch", 1'b1, 'h2F0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("relaunch.cnt4", 32'(s_cnt), 32'd0);
    cycle("relaunch_halt", 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run("relaunch_drop", 1'b0);

    // Randomized programs against the model.
    for (int i = 0; i < 800; i++) begin
      cycle("rand",
            $urandom_range(0, 3) != 0,
            int'($urandom_range(0, PC_MOD - 1)),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, PC_MOD - 1)),
            $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
